// File: rtl/sd_bd_fifo.sv
// sd_bd_fifo: buffer-descriptor FIFO. The producer writes descriptors one word
// at a time, and the consumer reads only fully committed descriptors. A free
// descriptor slot comes back on each rising edge of a_cmp.
// Optional sticky error flags are built only when SD_BD_ERR_EN is defined.
// Otherwise err_ovf and err_unf are tied to 0.
module sd_bd_fifo #(
  parameter int DW       = 32,
  parameter int BD_AW    = 3,
  parameter int WPB_LOG2 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_m,
  input  logic [DW-1:0]    dat_in_m,
  input  logic             flush,
  output logic [BD_AW:0]   free_bd,
  output logic             bd_avail,
  input  logic             re_s,
  output logic             ack_o_s,
  output logic [DW-1:0]    dat_out_s,
  input  logic             a_cmp,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam int AW        = BD_AW + WPB_LOG2;
  localparam int MEM_DEPTH = 1 << AW;
  localparam int CW        = BD_AW + 1;
  localparam logic [CW-1:0] BD_DEPTH  = CW'(1 << BD_AW);
  // Low pointer bits give the word index inside a descriptor. The pointers
  // start at 0 and advance by one, so no separate word counter is needed.
  localparam logic [AW-1:0] WORD_MASK = AW'((1 << WPB_LOG2) - 1);

  logic [DW-1:0] mem [MEM_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] free_q, free_d;
  logic [CW-1:0] ready_q, ready_d;
  logic          a_cmp_q, a_cmp_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] dat_out_q;

  logic          wr_acc;
  logic          commit;
  logic          avail;
  logic          rd_acc;
  logic          rd_first;
  logic          cmp_edge;
  logic          free_inc;
  logic [CW-1:0] free_after_commit;

  // Decode the strobes against the current registered state.
  always_comb begin
    wr_acc            = we_m && (free_q != '0);
    commit            = wr_acc && ((wr_ptr_q & WORD_MASK) == WORD_MASK);
    // Readable data is either a whole ready descriptor or the rest of one
    // that has already been started.
    avail             = (ready_q != '0) || ((rd_ptr_q & WORD_MASK) != '0);
    rd_acc            = re_s && avail;
    rd_first          = rd_acc && ((rd_ptr_q & WORD_MASK) == '0);
    cmp_edge          = a_cmp && !a_cmp_q;
    free_after_commit = free_q - CW'(commit);
    // The check is on the value after commit. A commit and an a_cmp edge in
    // the same cycle therefore cancel out, even when free_bd is already full.
    free_inc          = cmp_edge && (free_after_commit < BD_DEPTH);
  end

  // Next-state logic for pointers, counters, a_cmp history and ack. Flush
  // takes priority over every strobe.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    free_d   = free_q;
    ready_d  = ready_q;
    a_cmp_d  = a_cmp_q;
    ack_d    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      free_d   = BD_DEPTH;
      ready_d  = '0;
      a_cmp_d  = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        ack_d    = 1'b1;
      end
      ready_d = ready_q + CW'(commit) - CW'(rd_first);
      free_d  = free_after_commit + CW'(free_inc);
      a_cmp_d = a_cmp;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      free_q   <= BD_DEPTH;
      ready_q  <= '0;
      a_cmp_q  <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      free_q   <= free_d;
      ready_q  <= ready_d;
      a_cmp_q  <= a_cmp_d;
      ack_q    <= ack_d;
    end
  end

  // Descriptor memory write port. The memory has no reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush && !rst) begin
      mem[wr_ptr_q] <= dat_in_m;
    end
  end

  // Registered read port. A read of the address being written in the same
  // cycle returns the old word. The data register holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_out_q <= '0;
    end else if (rd_acc && !flush) begin
      dat_out_q <= mem[rd_ptr_q];
    end
  end

`ifdef SD_BD_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_unf_q, err_unf_d;

  // Sticky error flags. Only reset or flush clears them.
  always_comb begin
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    if (flush) begin
      err_ovf_d = 1'b0;
      err_unf_d = 1'b0;
    end else begin
      if (we_m && (free_q == '0)) err_ovf_d = 1'b1;
      if (re_s && !avail)         err_unf_d = 1'b1;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

  assign free_bd   = free_q;
  assign bd_avail  = avail;
  assign ack_o_s   = ack_q;
  assign dat_out_s = dat_out_q;

endmodule
